// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch direction predictor.
package bp_pkg;

    typedef logic [1:0] sat_cnt_t;

    localparam sat_cnt_t SNT = 2'b00;
    localparam sat_cnt_t WNT = 2'b01;
    localparam sat_cnt_t WT  = 2'b10;
    localparam sat_cnt_t ST  = 2'b11;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    function automatic sat_cnt_t sat_update(sat_cnt_t c, logic taken);
        if (taken) begin
            return (c == ST) ? ST : sat_cnt_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : sat_cnt_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/pattern_history_table.sv
// Table of 2-bit saturating counters: combinational read, read-modify-write update port.
module pattern_history_table
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output sat_cnt_t               rd_cnt,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic                   wr_taken
);

    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

    sat_cnt_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: WNT};
        end else if (wr_en) begin
            mem[wr_idx] <= sat_update(mem[wr_idx], wr_taken);
        end
    end

    // No bypass: a same-cycle write to rd_idx is seen by the reader next cycle.
    assign rd_cnt = mem[rd_idx];

endmodule

// File: rtl/pc_decode.sv
// Fetch-stage decode of RV32 conditional branches and JAL: sequential and target PC.
module pc_decode (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] pc_plus_4,
    output logic [31:0] pc_next,
    output logic        is_branch,
    output logic        is_jump
);

    logic [31:0] imm_b;
    logic [31:0] imm_j;

    always_comb begin
        imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        is_branch = (instr[6:0] == 7'b1100011);
        is_jump   = (instr[6:0] == 7'b1101111);
        pc_plus_4 = pc + 32'd4;
        pc_next   = pc + (is_jump ? imm_j : imm_b);
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage direction predictor (bimodal or gshare) with speculative GHR,
// F->D prediction snapshot, D-stage resolution and saturating statistics.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 10,
    parameter int unsigned GHR_WIDTH   = 8,
    parameter int unsigned MODE        = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush_d,
    input  logic [31:0]          pc_f,
    input  logic [31:0]          instr_f,
    input  logic                 is_branch_d,
    input  logic                 taken_d,
    output logic [31:0]          predict_pc,
    output logic                 pred_taken_d,
    output logic                 mispredict_d,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam bp_mode_e MODE_E = (MODE != 0) ? BP_GSHARE : BP_BIMODAL;

    logic [31:0]            pc_plus_4;
    logic [31:0]            pc_next;
    logic                   is_branch_f;
    logic                   is_jump_f;
    logic [GHR_WIDTH-1:0]   ghr;
    logic [GHR_WIDTH-1:0]   ghr_repair;
    logic [GHR_WIDTH-1:0]   ghr_spec;
    logic [INDEX_WIDTH-1:0] ghr_idx;
    logic [INDEX_WIDTH-1:0] idx_f;
    sat_cnt_t               cnt_f;
    logic                   pred_f;
    logic                   valid_d;
    logic [INDEX_WIDTH-1:0] index_d;
    logic [GHR_WIDTH-1:0]   ghr_d;
    logic                   resolve;
    logic                   commit;

    pc_decode u_pc_decode (
        .pc        (pc_f),
        .instr     (instr_f),
        .pc_plus_4 (pc_plus_4),
        .pc_next   (pc_next),
        .is_branch (is_branch_f),
        .is_jump   (is_jump_f)
    );

    pattern_history_table #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_f),
        .rd_cnt   (cnt_f),
        .wr_en    (commit),
        .wr_idx   (index_d),
        .wr_taken (taken_d)
    );

    always_comb begin
        ghr_idx    = (MODE_E == BP_GSHARE) ? INDEX_WIDTH'(ghr) : '0;
        idx_f      = pc_f[INDEX_WIDTH+1:2] ^ ghr_idx;
        pred_f     = (cnt_f == WT) || (cnt_f == ST);
        predict_pc = (is_jump_f | (is_branch_f & pred_f)) ? pc_next : pc_plus_4;
    end

    always_comb begin
        resolve      = valid_d & is_branch_d;
        mispredict_d = resolve & (taken_d != pred_taken_d);
        commit       = resolve & en;
    end

    if (GHR_WIDTH == 1) begin : g_ghr_one
        assign ghr_repair = taken_d;
        assign ghr_spec   = pred_f;
    end else begin : g_ghr_shift
        assign ghr_repair = {ghr_d[GHR_WIDTH-2:0], taken_d};
        assign ghr_spec   = {ghr[GHR_WIDTH-2:0], pred_f};
    end

    // Repair from the D snapshot takes priority over the speculative F shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (en) begin
            if (mispredict_d) begin
                ghr <= ghr_repair;
            end else if (is_branch_f & ~is_jump_f) begin
                ghr <= ghr_spec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_d      <= 1'b0;
            index_d      <= '0;
            ghr_d        <= '0;
            pred_taken_d <= 1'b0;
        end else if (en) begin
            valid_d      <= ~flush_d;
            index_d      <= idx_f;
            ghr_d        <= ghr;
            pred_taken_d <= is_branch_f & pred_f;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (commit) begin
            if (br_count != '1) begin
                br_count <= br_count + CNT_WIDTH'(1);
            end
            if (mispredict_d && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
